// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/interrupt control bus between the pipeline datapath and
// pipe_hazard_ctrl.
//   slave  : the controller (takes hazard/interrupt info, drives controls)
//   master : the datapath side (drives hazard/interrupt info, takes controls)
// Optional macro INT_MASK_EN adds the int_en interrupt enable signal.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 3
);
  logic                  int_req;
`ifdef INT_MASK_EN
  logic                  int_en;
`endif
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_write_add;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_use_src1;
  logic                  id_use_src2;
  logic                  ex_branch_taken;
  logic                  pc_en;
  logic                  fd_en;
  logic                  fd_flush;
  logic                  de_flush;
  logic                  int_push_hi;
  logic                  int_push_lo;
  logic                  int_load_vector;
  logic                  int_busy;
  logic                  int_ack;

  modport slave (
    input  int_req,
`ifdef INT_MASK_EN
    input  int_en,
`endif
    input  ex_mem_read, ex_write_add, id_src1, id_src2,
    input  id_use_src1, id_use_src2, ex_branch_taken,
    output pc_en, fd_en, fd_flush, de_flush,
    output int_push_hi, int_push_lo, int_load_vector, int_busy, int_ack
  );

  modport master (
    output int_req,
`ifdef INT_MASK_EN
    output int_en,
`endif
    output ex_mem_read, ex_write_add, id_src1, id_src2,
    output id_use_src1, id_use_src2, ex_branch_taken,
    input  pc_en, fd_en, fd_flush, de_flush,
    input  int_push_hi, int_push_lo, int_load_vector, int_busy, int_ack
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and interrupt-entry sequencer.
// Drives PC write enable, F/D load/flush and D/E flush. In IDLE it resolves
// taken branches (flush F/D and D/E) and load-use hazards (hold PC and F/D,
// bubble D/E). A pending interrupt runs IDLE -> DRAIN (DRAIN_CYCLES) ->
// PUSH_HI -> PUSH_LO -> VECTOR -> IDLE.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipe_hazard_ctrl_if.slave (hazard inputs, control outputs)
// Optional macro INT_MASK_EN: bus.int_en gates the start of the sequence.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,   // 1..15
  parameter int REG_ADDR_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_hazard_ctrl_if.slave    bus
);
  typedef enum logic [2:0] {IDLE, DRAIN, PUSH_HI, PUSH_LO, VECTOR} state_t;

  state_t     state;
  logic       int_pend;
  logic [3:0] drain_cnt;

  logic [REG_ADDR_W-1:0] wa, s1, s2;
  logic load_use, int_ok, start;

  assign wa = bus.ex_write_add;
  assign s1 = bus.id_src1;
  assign s2 = bus.id_src2;

  assign load_use = bus.ex_mem_read &
                    ((bus.id_use_src1 & (s1 == wa)) |
                     (bus.id_use_src2 & (s2 == wa)));

`ifdef INT_MASK_EN
  assign int_ok = bus.int_en;
`else
  assign int_ok = 1'b1;
`endif

  // Only start when the IDLE cycle is not itself busy with a hazard, so the
  // branch flush / load-use stall completes before draining.
  assign start = int_pend & int_ok & ~bus.ex_branch_taken & ~load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      int_pend  <= 1'b0;
      drain_cnt <= 4'd0;
    end else begin
      // A request arriving during VECTOR survives the clear (set wins).
      int_pend <= bus.int_req | (int_pend & (state != VECTOR));
      unique case (state)
        IDLE: if (start) begin
          state     <= DRAIN;
          drain_cnt <= 4'(DRAIN_CYCLES - 1);
        end
        DRAIN: begin
          if (drain_cnt == 4'd0) state <= PUSH_HI;
          else                   drain_cnt <= drain_cnt - 4'd1;
        end
        PUSH_HI: state <= PUSH_LO;
        PUSH_LO: state <= VECTOR;
        VECTOR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency outputs decoded from state and current hazard inputs.
  always_comb begin
    bus.pc_en           = 1'b1;
    bus.fd_en           = 1'b1;
    bus.fd_flush        = 1'b0;
    bus.de_flush        = 1'b0;
    bus.int_push_hi     = 1'b0;
    bus.int_push_lo     = 1'b0;
    bus.int_load_vector = 1'b0;
    bus.int_ack         = 1'b0;
    bus.int_busy        = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (bus.ex_branch_taken) begin
          bus.fd_flush = 1'b1;
          bus.de_flush = 1'b1;
        end else if (load_use) begin
          bus.pc_en    = 1'b0;
          bus.fd_en    = 1'b0;
          bus.de_flush = 1'b1;
        end
      end
      DRAIN: begin
        // A branch resolving here still updates PC so the saved return
        // address is the branch target.
        bus.pc_en    = bus.ex_branch_taken;
        bus.fd_flush = 1'b1;
        bus.de_flush = 1'b1;
      end
      PUSH_HI: begin
        bus.pc_en       = 1'b0;
        bus.fd_flush    = 1'b1;
        bus.de_flush    = 1'b1;
        bus.int_push_hi = 1'b1;
      end
      PUSH_LO: begin
        bus.pc_en       = 1'b0;
        bus.fd_flush    = 1'b1;
        bus.de_flush    = 1'b1;
        bus.int_push_lo = 1'b1;
      end
      VECTOR: begin
        bus.fd_flush        = 1'b1;
        bus.de_flush        = 1'b1;
        bus.int_load_vector = 1'b1;
        bus.int_ack         = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (DRAIN_CYCLES=3). Each step drives
// inputs, queues the expected control vector and compares on the falling edge.
// Vector order: {pc_en, fd_en, fd_flush, de_flush, push_hi, push_lo,
//                load_vector, busy, ack}
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(3)) bus();

  pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .REG_ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  localparam logic [8:0] NORM  = 9'b1100_0000_0;
  localparam logic [8:0] STALL = 9'b0001_0000_0;
  localparam logic [8:0] BR    = 9'b1111_0000_0;
  localparam logic [8:0] DRN   = 9'b0111_0001_0;
  localparam logic [8:0] DRNBR = 9'b1111_0001_0;
  localparam logic [8:0] PHI   = 9'b0111_1001_0;
  localparam logic [8:0] PLO   = 9'b0111_0101_0;
  localparam logic [8:0] VEC   = 9'b1111_0011_1;

  logic [8:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  function automatic logic [8:0] obs();
    return {bus.pc_en, bus.fd_en, bus.fd_flush, bus.de_flush, bus.int_push_hi,
            bus.int_push_lo, bus.int_load_vector, bus.int_busy, bus.int_ack};
  endfunction

  task automatic check(input string tag);
    logic [8:0] e, o;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      o = obs();
      n_chk++;
      assert (o === e) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", tag, o, e);
      end
    end
  endtask

  task automatic drive(input logic req, input logic mr, input logic [2:0] wa,
                       input logic [2:0] s1, input logic [2:0] s2,
                       input logic u1, input logic u2, input logic br);
    bus.int_req = req;        bus.ex_mem_read = mr;
    bus.ex_write_add = wa;    bus.id_src1 = s1;  bus.id_src2 = s2;
    bus.id_use_src1 = u1;     bus.id_use_src2 = u2;
    bus.ex_branch_taken = br;
  endtask

  // One clock cycle: inputs just after posedge, compare at negedge.
  task automatic step(input string tag, input logic [8:0] e,
                      input logic req = 0, input logic mr = 0,
                      input logic [2:0] wa = 0, input logic [2:0] s1 = 1,
                      input logic [2:0] s2 = 1, input logic u1 = 0,
                      input logic u2 = 0, input logic br = 0);
    drive(req, mr, wa, s1, s2, u1, u2, br);
    exp_q.push_back(e);
    @(negedge clk);
    check(tag);
    @(posedge clk); #1;
  endtask

  initial begin
`ifdef INT_MASK_EN
    bus.int_en = 1'b1;
`endif
    drive(0, 0, 0, 1, 1, 0, 0, 0);
    #2;
    exp_q.push_back(NORM);
    check("reset_state");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    step("idle_normal", NORM);
    step("lu_src1",    STALL, 0, 1, 3'd2, 3'd2, 3'd5, 1, 0, 0);
    step("lu_release", NORM);
    step("lu_src2",    STALL, 0, 1, 3'd4, 3'd1, 3'd4, 0, 1, 0);
    step("lu_nouse",   NORM,  0, 1, 3'd2, 3'd2, 3'd2, 0, 0, 0);
    step("lu_noload",  NORM,  0, 0, 3'd2, 3'd2, 3'd5, 1, 0, 0);
    step("lu_diffreg", NORM,  0, 1, 3'd3, 3'd2, 3'd5, 1, 1, 0);
    step("br_over_lu", BR,    0, 1, 3'd2, 3'd2, 3'd5, 1, 0, 1);

    // Interrupt; pending IDLE cycle blocked once by load-use.
    step("int_req",     NORM, 1);
    step("pend_lu",     STALL, 0, 1, 3'd6, 3'd6, 3'd1, 1, 0, 0);
    step("pend_idle",   NORM);
    step("drain1",      DRN);
    step("drain2_lu",   DRN,  0, 1, 3'd2, 3'd2, 3'd5, 1, 0, 0);
    step("drain3",      DRN);
    step("push_hi",     PHI);
    step("push_lo",     PLO);
    step("vector",      VEC);
    step("post_idle1",  NORM);
    step("post_idle2",  NORM);

    // Branch in first DRAIN cycle, re-request during VECTOR.
    step("int_req2",    NORM, 1);
    step("pend_idle2",  NORM);
    step("drain1_br",   DRNBR, 0, 0, 3'd0, 3'd1, 3'd1, 0, 0, 1);
    step("drain2b",     DRN);
    step("drain3b",     DRN);
    step("push_hi2",    PHI);
    step("push_lo2",    PLO);
    step("vector_rereq", VEC, 1);
    step("gap_idle",    NORM);
    step("drain1c",     DRN);
    step("drain2c",     DRN);
    step("drain3c",     DRN);

    // Reset asserted mid-PUSH_HI takes effect immediately.
    drive(0, 0, 0, 1, 1, 0, 0, 0);
    exp_q.push_back(PHI);
    @(negedge clk);
    check("push_hi3");
    rst_n = 1'b0;
    #1;
    exp_q.push_back(NORM);
    check("reset_mid_push");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    step("pend_cleared1", NORM);
    step("pend_cleared2", NORM);
    step("pend_cleared3", NORM);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer that drives the F/D and D/E buffer control inputs (enable, flush) and the PC write enable.
- Detects load-use hazards and taken branches resolved in Execute.
- Runs a multi-cycle interrupt entry sequence: drain pipeline, push 32-bit PC as two 16-bit halves, load vector.
- Sits beside the Control Unit; its outputs feed PC register, FD buffer, DE buffer flush and the stack/PC-select logic.

Parameters:
DRAIN_CYCLES, 3, number of bubble cycles inserted before the PC push (legal range 1..15)
REG_ADDR_W, 3, register address width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
int_req  input  1  external interrupt request, level, sampled on clk
ex_mem_read  input  1  instruction in Execute is a load
ex_write_add  input  REG_ADDR_W  destination register of instruction in Execute
id_src1  input  REG_ADDR_W  source register 1 of instruction in Decode
id_src2  input  REG_ADDR_W  source register 2 of instruction in Decode
id_use_src1  input  1  Decode instruction reads src1
id_use_src2  input  1  Decode instruction reads src2
ex_branch_taken  input  1  branch/jump in Execute resolved taken
pc_en  output  1  PC register write enable
fd_en  output  1  F/D buffer load enable (0 = hold)
fd_flush  output  1  F/D buffer flush
de_flush  output  1  D/E buffer flush (bubble)
int_push_hi  output  1  push PC[31:16] this cycle
int_push_lo  output  1  push PC[15:0] this cycle
int_load_vector  output  1  PC mux selects interrupt vector
int_busy  output  1  interrupt sequence in progress (state != IDLE)
int_ack  output  1  one-cycle acknowledge of serviced interrupt

Behaviour:
- Reset (async, rst_n=0): state=IDLE, int_pend=0, drain_cnt=0. Outputs: pc_en=1, fd_en=1, all flush/push/vector/ack/busy=0. Reset mid-sequence aborts to IDLE and discards the pending request.
- int_pend register: set on any clk edge with int_req=1; cleared on the edge leaving VECTOR. Set wins over clear, so a request seen during VECTOR stays pending.
- Outputs are combinational from state and inputs, with zero latency.
- load_use = ex_mem_read & ((id_use_src1 & id_src1==ex_write_add) | (id_use_src2 & id_src2==ex_write_add)).
- IDLE priority, highest first:
  (1) ex_branch_taken: pc_en=1, fd_en=1, fd_flush=1, de_flush=1; load_use ignored.
  (2) load_use: pc_en=0, fd_en=0, de_flush=1, fd_flush=0; stall lasts exactly while load_use holds (normally 1 cycle).
  (3) Otherwise: pc_en=1, fd_en=1, no flush.
- IDLE->DRAIN: at the edge where int_pend=1 and neither branch nor load_use is active this cycle; drain_cnt loads DRAIN_CYCLES-1.
- DRAIN: pc_en=0, fd_flush=1, de_flush=1, busy=1. Exception: ex_branch_taken forces pc_en=1 for that cycle so the saved return PC is the branch target. drain_cnt decrements each cycle; at 0, next state is PUSH_HI.
- PUSH_HI, 1 cycle: int_push_hi=1, pc_en=0, fd_flush=1, de_flush=1. Next state PUSH_LO.
- PUSH_LO, 1 cycle: int_push_lo=1, same hold/flush. Next state VECTOR.
- VECTOR, 1 cycle: int_load_vector=1, pc_en=1, int_ack=1, fd_flush=1, de_flush=1. Next state IDLE.
- In every non-IDLE state: fd_en=1 (flush dominates), int_busy=1. load_use has no effect.
- Total entry latency from IDLE decision: DRAIN_CYCLES+3 cycles; first fetch from the vector occurs in the cycle after VECTOR.

Optional Feature:
INT_MASK_EN: adds input port int_en (1 bit). When int_en=0, IDLE never starts the sequence; int_pend is retained and serviced once int_en=1. A sequence already started is unaffected by int_en. Without the macro the port is absent and interrupts are always enabled.

Test Plan:
- Reset: rst_n=0 asserted mid-PUSH_HI -> same instant state=IDLE, pc_en=1, fd_en=1, int_push_hi=0, int_busy=0; int_pend cleared.
- Load-use: ex_mem_read=1, ex_write_add=2, id_src1=2, id_use_src1=1 for one cycle -> pc_en=0, fd_en=0, de_flush=1 that cycle only; next cycle all normal.
- Branch vs load-use: load_use and ex_branch_taken both 1 -> pc_en=1, fd_flush=1, de_flush=1, fd_en=1.
- Interrupt, DRAIN_CYCLES=3: int_req pulsed 1 cycle in IDLE -> 3 DRAIN cycles, then push_hi, push_lo, vector+ack one cycle each; int_busy high 6 cycles; pc_en=0 for 5 of them.
- Branch during DRAIN: ex_branch_taken=1 in first DRAIN cycle -> pc_en=1 that cycle only; sequence length unchanged.
- Re-request in VECTOR: int_req=1 in VECTOR cycle -> IDLE for one cycle, then a second sequence starts (int_pend stayed 1).
